// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris move scheduler: command codes, FSM states, gravity defaults.
package tetris_pkg;

  localparam int GRAV_BASE_DEF = 48;
  localparam int GRAV_STEP_DEF = 4;
  localparam int GRAV_MIN_DEF  = 2;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

endpackage

// File: rtl/gravity_timer.sv
// Frame-paced gravity: counts registered VS rising edges, raises grav_pend once per level-dependent period.
// VS rise sampled at edge k -> edge flag at k+1 -> grav_pend at k+2; no backpressure, pending is a sticky flag.
module gravity_timer
  import tetris_pkg::*;
#(
  parameter int GRAV_BASE = GRAV_BASE_DEF,
  parameter int GRAV_STEP = GRAV_STEP_DEF,
  parameter int GRAV_MIN  = GRAV_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] level,
  input  logic       sync_vs,
  input  logic       pend_clr,
  input  logic       cnt_clr,
  output logic       grav_pend
);

  logic       vs_s, vs_d, vs_rise;
  logic [7:0] grav_cnt;
  logic [7:0] dec, period;
  logic       grav_hit;

  // Subtraction is guarded so a high level clamps to GRAV_MIN instead of wrapping.
  always_comb begin
    dec    = 8'(level) * 8'(GRAV_STEP);
    period = 8'(GRAV_MIN);
    if ((8'(GRAV_BASE) > dec) && ((8'(GRAV_BASE) - dec) > 8'(GRAV_MIN)))
      period = 8'(GRAV_BASE) - dec;
    grav_hit = (grav_cnt >= (period - 8'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s      <= 1'b0;
      vs_d      <= 1'b0;
      vs_rise   <= 1'b0;
      grav_cnt  <= 8'd0;
      grav_pend <= 1'b0;
    end else begin
      vs_s    <= sync_vs;
      vs_d    <= vs_s;
      vs_rise <= vs_s & ~vs_d;

      if (!enable || cnt_clr)
        grav_cnt <= 8'd0;
      else if (vs_rise)
        grav_cnt <= grav_hit ? 8'd0 : grav_cnt + 8'd1;

      if (!enable)
        grav_pend <= 1'b0;
      else if (vs_rise && grav_hit)
        grav_pend <= 1'b1;
      else if (pend_clr)
        grav_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/tetris_move_sched.sv
// Move scheduler: latches button requests and gravity, issues one command at a time, sequences hard drop and lock.
// Pulse to cmd_valid is 2 cycles; cmd held stable while i_cmd_ready is low, new requests stay latched meanwhile.
module tetris_move_sched
  import tetris_pkg::*;
#(
  parameter int GRAV_BASE = GRAV_BASE_DEF,
  parameter int GRAV_STEP = GRAV_STEP_DEF,
  parameter int GRAV_MIN  = GRAV_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [3:0] i_level,
  input  logic       i_pls_c,
  input  logic       i_pls_w,
  input  logic       i_pls_e,
  input  logic       i_pls_s,
  input  logic       i_pls_n,
  input  logic       i_sync_vs,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd,
  input  logic       i_cmd_ready,
  input  logic       i_res_valid,
  input  logic       i_res_blocked,
  output logic       o_lock,
  output logic       o_busy,
  output logic [4:0] o_drop_rows
);

  state_t     state, state_nxt;
  logic       pend_c, pend_w, pend_e, pend_s, pend_n;
  logic       grav_pend;
  logic       hd_mode, hd_nxt;
  logic [2:0] cmd_nxt;
  logic [4:0] drop_nxt;
  logic       hs, down_hs, lock_st, any_pend;

  assign hs       = (state == ST_ISSUE) && i_cmd_ready;
  assign down_hs  = hs && (o_cmd == CMD_DOWN);
  assign lock_st  = (state == ST_LOCK);
  assign any_pend = pend_n | pend_c | pend_w | pend_e | pend_s | grav_pend;

  gravity_timer #(
    .GRAV_BASE (GRAV_BASE),
    .GRAV_STEP (GRAV_STEP),
    .GRAV_MIN  (GRAV_MIN)
  ) u_grav (
    .clk       (clk),
    .rst       (rst),
    .enable    (i_enable),
    .level     (i_level),
    .sync_vs   (i_sync_vs),
    .pend_clr  (down_hs | lock_st),
    .cnt_clr   (lock_st),
    .grav_pend (grav_pend)
  );

  // Set beats clear; disable forces every request flag low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_c <= 1'b0;
      pend_w <= 1'b0;
      pend_e <= 1'b0;
      pend_s <= 1'b0;
      pend_n <= 1'b0;
    end else if (!i_enable) begin
      pend_c <= 1'b0;
      pend_w <= 1'b0;
      pend_e <= 1'b0;
      pend_s <= 1'b0;
      pend_n <= 1'b0;
    end else begin
      if (i_pls_c) pend_c <= 1'b1;
      else if (lock_st || (hs && o_cmd == CMD_ROT)) pend_c <= 1'b0;
      if (i_pls_w) pend_w <= 1'b1;
      else if (lock_st || (hs && o_cmd == CMD_LEFT)) pend_w <= 1'b0;
      if (i_pls_e) pend_e <= 1'b1;
      else if (lock_st || (hs && o_cmd == CMD_RIGHT)) pend_e <= 1'b0;
      if (i_pls_s) pend_s <= 1'b1;
      else if (lock_st || down_hs) pend_s <= 1'b0;
      if (i_pls_n) pend_n <= 1'b1;
      else if (lock_st || (down_hs && hd_mode)) pend_n <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = o_cmd;
    hd_nxt    = hd_mode;
    drop_nxt  = o_drop_rows;
    case (state)
      ST_IDLE: begin
        if (i_enable && any_pend) begin
          state_nxt = ST_ISSUE;
          if (pend_n) begin
            cmd_nxt  = CMD_DOWN;
            hd_nxt   = 1'b1;
            drop_nxt = 5'd0;
          end else if (pend_c) cmd_nxt = CMD_ROT;
          else if (pend_w)     cmd_nxt = CMD_LEFT;
          else if (pend_e)     cmd_nxt = CMD_RIGHT;
          else                 cmd_nxt = CMD_DOWN;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_res_valid) begin
          if ((o_cmd == CMD_DOWN) && i_res_blocked) begin
            state_nxt = ST_LOCK;
          end else if (hd_mode && !i_res_blocked) begin
            state_nxt = ST_ISSUE;
            cmd_nxt   = CMD_DOWN;
            drop_nxt  = (o_drop_rows == 5'd31) ? 5'd31 : o_drop_rows + 5'd1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        state_nxt = ST_IDLE;
        hd_nxt    = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hd_mode     <= 1'b0;
      o_cmd       <= CMD_NOP;
      o_cmd_valid <= 1'b0;
      o_lock      <= 1'b0;
      o_busy      <= 1'b0;
      o_drop_rows <= 5'd0;
    end else begin
      state       <= state_nxt;
      hd_mode     <= hd_nxt;
      o_cmd       <= cmd_nxt;
      o_cmd_valid <= (state_nxt == ST_ISSUE);
      o_lock      <= (state_nxt == ST_LOCK);
      o_busy      <= (state_nxt != ST_IDLE);
      o_drop_rows <= drop_nxt;
    end
  end

endmodule

// File: doc/tetris_move_sched.md
# tetris_move_sched

Move scheduler for the Tetris core. It sits between the debounced button pulses from `button_detector` and the board/collision datapath. It latches player requests and generates frame-paced gravity from the display vertical sync. It issues one move command at a time to the board over a valid/ready handshake, waits for the collision result, and signals piece lock. Hard drop is sequenced here as a burst of DOWN commands that ends in a lock.

## Interface
Parameters:
- `GRAV_BASE`, 48: gravity period in frames at level 0.
- `GRAV_STEP`, 4: frames subtracted per level.
- `GRAV_MIN`, 2: minimum gravity period in frames.

Ports:
- `clk`  in  1  system/display clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  game running; low means no new commands are issued.
- `i_level`  in  4  speed level, 0..15.
- `i_pls_c` / `i_pls_w` / `i_pls_e` / `i_pls_s` / `i_pls_n`  in  1 each  one-cycle pulses: rotate, left, right, soft drop, hard drop.
- `i_sync_vs`  in  1  vertical sync from `sync_gen`, level signal.
- `o_cmd_valid`  out  1  command offered.
- `o_cmd`  out  3  command code.
- `i_cmd_ready`  in  1  board accepts the command.
- `i_res_valid`  in  1  collision result strobe.
- `i_res_blocked`  in  1  move was rejected; qualified by `i_res_valid`.
- `o_lock`  out  1  one-cycle pulse: piece locked.
- `o_busy`  out  1  state is not IDLE.
- `o_drop_rows`  out  5  rows fallen in the last hard drop; saturates at 31.

## Operation
- Command codes: NOP=0, LEFT=1, RIGHT=2, ROT=3, DOWN=4.
- Each button pulse sets its pending flag (`c`, `w`, `e`, `s`, `n`).
  - A flag clears when its command completes the handshake.
  - If a set and a clear land in the same cycle, the set wins.
- Gravity:
  - Period = max(`GRAV_MIN`, `GRAV_BASE` − `i_level`·`GRAV_STEP`), computed in 8 bits with no underflow.
  - `grav_cnt` (8 bits) advances on each registered rising edge of `i_sync_vs`.
  - When `grav_cnt` ≥ period−1: set `grav_pend` and reset `grav_cnt` to 0.
- Selection priority, evaluated in IDLE: `n` (starts hard drop) > `c` > `w` > `e` > (`s` or `grav_pend`) → DOWN.
  - A DOWN handshake clears both `s` and `grav_pend`.
- FSM states and transitions:
  - IDLE: if `i_enable` and any flag is pending → ISSUE, with `o_cmd` registered.
    - On a hard drop, also set `hd_mode` and clear `o_drop_rows`.
  - ISSUE: `o_cmd_valid`=1 and `o_cmd` held stable until `i_cmd_ready`; then → WAIT.
  - WAIT: on `i_res_valid`:
    - DOWN and blocked → LOCK.
    - `hd_mode` and not blocked → `o_drop_rows`+1, → ISSUE with DOWN.
    - Any other result → IDLE.
  - LOCK: `o_lock`=1 for one cycle; clear all pending flags, `grav_cnt` and `hd_mode`; → IDLE.
- During hard drop, newly arriving pulses stay latched but are discarded at LOCK.
- A blocked LEFT/RIGHT/ROT only returns to IDLE; no lock.
- `i_enable` low:
  - Pending flags and `grav_cnt` are held at 0.
  - A transaction already in ISSUE or WAIT runs to completion, including LOCK.
- `i_res_valid` outside WAIT is ignored.

## Timing
- Reset values: `o_cmd_valid`=0, `o_cmd`=NOP, `o_lock`=0, `o_busy`=0, `o_drop_rows`=0, state IDLE, all flags 0, `grav_cnt`=0.
- All outputs are registered.
- Latency:
  - Pulse in cycle 0 → flag set at edge 1 → `o_cmd_valid` high in cycle 2.
  - `i_sync_vs` rise sampled at edge k → edge detected at k+1 → `grav_pend` set at k+2.
- Handshake: transfer occurs on a cycle with `o_cmd_valid`&&`i_cmd_ready`.
  - `o_cmd_valid` drops the following cycle.
  - The earliest accepted `i_res_valid` is the cycle after transfer.
- Hard-drop re-issue: unblocked result in cycle t → next DOWN has `o_cmd_valid` high in cycle t+1.
- Lock: blocked DOWN result in cycle t → `o_lock` high in cycle t+1 → IDLE at t+2.
- Reset mid-transaction drops `o_cmd_valid` immediately (asynchronous).

## Structure
- Package `tetris_pkg`: command code constants, FSM state encoding, `GRAV_*` defaults.
- Sub-module `gravity_timer`: VS edge detect, period computation, `grav_cnt`, `grav_pend` output with a clear input.
- Request latches, priority select and FSM stay in the top.

## Test plan
- Pulse `i_pls_w` at cycle 0, `i_cmd_ready`=1 → `o_cmd_valid`=1 with `o_cmd`=1 in cycle 2. `i_res_valid`/`i_res_blocked`=0 → IDLE, no lock.
- Pulse `c`, `w`, `e` in the same cycle → commands issued in order ROT, LEFT, RIGHT, each after the previous result.
- `i_level`=15 (period clamped to 2), 6 VS pulses → exactly 3 DOWN commands. At `i_level`=0, 48 VS pulses → 1 DOWN.
- Hard drop with the board blocking on the 6th DOWN → 6 DOWN handshakes, `o_drop_rows`=5, one `o_lock` pulse, all flags cleared.
- Hold `i_cmd_ready`=0 for 10 cycles → `o_cmd_valid` and `o_cmd` stay stable. Pulse `i_pls_e` during the stall → RIGHT issued after the current result.
- Assert `rst` while in WAIT → all outputs return to reset values the same cycle. A later `i_res_valid` is ignored.
